// File: rtl/spi_cmd_decoder_if.sv
// Byte-level link between the SPI byte receiver and the command decoder.
// The receiver side is the master; the decoder side is the slave.
interface spi_cmd_decoder_if;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  // rx_valid is a one-cycle strobe qualified by frame_active; no backpressure exists
  modport master (output frame_active, output rx_valid, output rx_byte, input tx_byte);
  modport slave  (input frame_active, input rx_valid, input rx_byte, output tx_byte);
endinterface

// File: rtl/spi_cmd_decoder.sv
// Parses each SPI frame as command/address/data, writes a register bank and
// supplies the reply byte for the next exchange.
module spi_cmd_decoder #(
  parameter int NREGS = 8,
  parameter int ERR_W = 8
) (
  input  logic                 ico_clk,
  input  logic                 rst,
  spi_cmd_decoder_if.slave     bus,
  output logic                 wr_strobe,
  output logic [3:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic [8*NREGS-1:0]   reg_flat,
  output logic [ERR_W-1:0]     err_count,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WADDR   = 3'd2,
    S_RADDR   = 3'd3,
    S_WDATA   = 3'd4,
    S_RDATA   = 3'd5,
    S_STAT    = 3'd6,
    S_DISCARD = 3'd7
  } state_t;

  localparam int         EW      = (ERR_W < 8) ? ERR_W : 8;
  localparam logic [7:0] NREGS_B = 8'(NREGS);
  localparam logic [3:0] LAST    = 4'(NREGS - 1);

  state_t               state_q, state_d;
  logic [3:0]           ptr_q, ptr_d;
  logic [7:0]           tx_q, tx_d;
  logic                 wr_strobe_q, wr_strobe_d;
  logic [3:0]           wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [8*NREGS-1:0]   regs_q, regs_d;
  logic [ERR_W-1:0]     err_q, err_d;

  logic                 accept;
  logic [3:0]           ptr_inc;
  logic [7:0]           err_byte;
  logic [ERR_W-1:0]     err_inc;
  logic                 addr_ok;

  function automatic logic [7:0] reg_at(input logic [8*NREGS-1:0] r, input logic [3:0] a);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NREGS; i++) begin
      if (a == 4'(i)) v = r[8*i +: 8];
    end
    return v;
  endfunction

  assign accept   = bus.frame_active & bus.rx_valid;
  assign ptr_inc  = (ptr_q == LAST) ? 4'd0 : ptr_q + 4'd1;
  assign err_byte = 8'(err_q[EW-1:0]);
  assign err_inc  = (&err_q) ? err_q : err_q + 1'b1;
  assign addr_ok  = bus.rx_byte < NREGS_B;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
    err_d       = err_q;
    // Chip-select low drops any partial packet without counting it as an error
    if (!bus.frame_active) begin
      state_d = S_IDLE;
      tx_d    = 8'h00;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: if (accept) begin
          case (bus.rx_byte)
            8'h01:   begin state_d = S_WADDR; tx_d = 8'h01; end
            8'h02:   begin state_d = S_RADDR; tx_d = 8'h02; end
            8'h03:   begin state_d = S_STAT;  tx_d = err_byte; end
            default: begin state_d = S_DISCARD; tx_d = 8'h00; err_d = err_inc; end
          endcase
        end
        S_WADDR, S_RADDR: if (accept) begin
          if (addr_ok) begin
            ptr_d   = bus.rx_byte[3:0];
            state_d = (state_q == S_WADDR) ? S_WDATA : S_RDATA;
            tx_d    = (state_q == S_WADDR) ? 8'h00 : reg_at(regs_q, bus.rx_byte[3:0]);
          end else begin
            state_d = S_DISCARD;
            tx_d    = 8'h00;
            err_d   = err_inc;
          end
        end
        S_WDATA: if (accept) begin
          for (int i = 0; i < NREGS; i++) begin
            if (ptr_q == 4'(i)) regs_d[8*i +: 8] = bus.rx_byte;
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = ptr_q;
          wr_data_d   = bus.rx_byte;
          ptr_d       = ptr_inc;
          tx_d        = 8'h00;
        end
        // The reply prefetches the register the next dummy byte will read
        S_RDATA: if (accept) begin
          ptr_d = ptr_inc;
          tx_d  = reg_at(regs_q, ptr_inc);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ico_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 4'd0;
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
      regs_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
      err_q       <= err_d;
    end
  end

  assign bus.tx_byte = tx_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign reg_flat    = regs_q;
  assign err_count   = err_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed and random frames against a frame-level model of the command protocol;
// a second instance with a 2-bit error counter shares the same traffic.
module tb_spi_cmd_decoder;
  localparam int NREGS = 8;

  logic ico_clk;
  logic rst;

  spi_cmd_decoder_if bus ();
  spi_cmd_decoder_if bus2 ();

  logic        wr_strobe, wr_strobe2;
  logic [3:0]  wr_addr, wr_addr2;
  logic [7:0]  wr_data, wr_data2;
  logic [63:0] reg_flat, reg_flat2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
  logic        busy, busy2;
  logic [2:0]  dbg_state, dbg_state2;

  spi_cmd_decoder #(.NREGS(NREGS), .ERR_W(8)) dut (
    .ico_clk(ico_clk), .rst(rst), .bus(bus),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_flat(reg_flat), .err_count(err_count), .busy(busy), .dbg_state(dbg_state)
  );

  spi_cmd_decoder #(.NREGS(NREGS), .ERR_W(2)) dut_sat (
    .ico_clk(ico_clk), .rst(rst), .bus(bus2),
    .wr_strobe(wr_strobe2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .reg_flat(reg_flat2), .err_count(err_count2), .busy(busy2), .dbg_state(dbg_state2)
  );

  assign bus2.frame_active = bus.frame_active;
  assign bus2.rx_valid     = bus.rx_valid;
  assign bus2.rx_byte      = bus.rx_byte;

  // clock / reset
  initial ico_clk = 1'b0;
  always #5 ico_clk = ~ico_clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]  m_regs [NREGS];
  int          m_err;
  logic [7:0]  cur [$];
  logic [7:0]  exp_tx;
  logic [11:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  function automatic logic [7:0] err8();
    return (m_err > 255) ? 8'd255 : 8'(m_err);
  endfunction

  function automatic logic [1:0] err2();
    return (m_err > 3) ? 2'd3 : 2'(m_err);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_err = 0;
    cur.delete();
    exp_q.delete();
  endtask

  // Reply and side effects of the newest byte, derived from its position in the frame
  task automatic model_byte(input logic [7:0] b);
    int n;
    int a;
    logic [7:0] cmd;
    cur.push_back(b);
    n = cur.size() - 1;
    cmd = cur[0];
    exp_tx = 8'h00;
    if (n == 0) begin
      if (cmd == 8'h01 || cmd == 8'h02) exp_tx = cmd;
      else if (cmd == 8'h03) exp_tx = err8();
      else m_err++;
    end else if (cmd == 8'h01) begin
      if (n == 1) begin
        if (cur[1] >= NREGS) m_err++;
      end else if (cur[1] < NREGS) begin
        a = (int'(cur[1]) + n - 2) % NREGS;
        m_regs[a] = cur[n];
        exp_q.push_back({4'(a), cur[n]});
      end
    end else if (cmd == 8'h02) begin
      if (cur[1] >= NREGS) begin
        if (n == 1) m_err++;
      end else begin
        a = (int'(cur[1]) + n - 1) % NREGS;
        exp_tx = m_regs[a];
      end
    end else if (cmd == 8'h03) begin
      exp_tx = err8();
    end
  endtask

  // write-strobe scoreboard
  always @(negedge ico_clk) begin
    if (!rst && wr_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_strobe", {52'd0, wr_addr, wr_data}, 64'hFFF);
      end else begin
        check("wr_addr_data", {52'd0, wr_addr, wr_data}, {52'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks: all start and end just after a falling edge
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge ico_clk);
  endtask

  task automatic start_frame();
    cur.delete();
    bus.frame_active = 1'b1;
    idle(2);
    check("busy_in_frame", {63'd0, busy}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge ico_clk);
    bus.rx_valid = 1'b0;
    check($sformatf("tx_after_%0h_pos%0d", b, cur.size() - 1), {56'd0, bus.tx_byte}, {56'd0, exp_tx});
    idle(2);
  endtask

  task automatic end_frame();
    bus.frame_active = 1'b0;
    cur.delete();
    idle(2);
    check("busy_after_frame", {63'd0, busy}, 64'd0);
    check("tx_after_frame", {56'd0, bus.tx_byte}, 64'd0);
    check("reg_flat", reg_flat, model_flat());
    check("err_count", {56'd0, err_count}, {56'd0, err8()});
    check("err_count_sat", {62'd0, err_count2}, {62'd0, err2()});
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int len;
    logic [7:0] b;
    rst = 1'b1;
    bus.frame_active = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(1);

    // reset state
    check("rst_tx", {56'd0, bus.tx_byte}, 64'd0);
    check("rst_wr_strobe", {63'd0, wr_strobe}, 64'd0);
    check("rst_wr_addr", {60'd0, wr_addr}, 64'd0);
    check("rst_wr_data", {56'd0, wr_data}, 64'd0);
    check("rst_reg_flat", reg_flat, 64'd0);
    check("rst_err", {56'd0, err_count}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);

    // basic write
    start_frame();
    send_byte(8'h01); send_byte(8'h03); send_byte(8'h5A); send_byte(8'hC3);
    end_frame();
    check("reg3", {56'd0, reg_flat[31:24]}, 64'h5A);
    check("reg4", {56'd0, reg_flat[39:32]}, 64'hC3);

    // preload reg7/reg0 with a wrapping write, then read across the wrap
    start_frame();
    send_byte(8'h01); send_byte(8'h07); send_byte(8'h11); send_byte(8'h22);
    end_frame();
    start_frame();
    send_byte(8'h02); send_byte(8'h07); send_byte(8'hFF); send_byte(8'hFF);
    end_frame();

    // protocol errors and status read
    start_frame(); send_byte(8'h7E); send_byte(8'h01); end_frame();
    start_frame(); send_byte(8'h01); send_byte(8'h09); end_frame();
    start_frame(); send_byte(8'h03); end_frame();

    // frame abort before data, then a complete write
    start_frame(); send_byte(8'h01); send_byte(8'h02); end_frame();
    start_frame(); send_byte(8'h01); send_byte(8'h02); send_byte(8'h44); end_frame();

    // rx_valid outside a frame
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h01;
    @(negedge ico_clk);
    bus.rx_valid = 1'b0;
    check("unframed_busy", {63'd0, busy}, 64'd0);
    check("unframed_tx", {56'd0, bus.tx_byte}, 64'd0);

    // rx_valid coinciding with frame end: bad command and a data byte both dropped
    start_frame();
    bus.frame_active = 1'b0; bus.rx_valid = 1'b1; bus.rx_byte = 8'h7E;
    @(negedge ico_clk);
    bus.rx_valid = 1'b0;
    end_frame();
    start_frame(); send_byte(8'h01); send_byte(8'h05);
    bus.frame_active = 1'b0; bus.rx_valid = 1'b1; bus.rx_byte = 8'h99;
    @(negedge ico_clk);
    bus.rx_valid = 1'b0;
    end_frame();

    // random frames
    for (int f = 0; f < 24; f++) begin
      start_frame();
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        if (k == 0) begin
          case ($urandom_range(0, 4))
            0, 4:    b = 8'h01;
            1:       b = 8'h02;
            2:       b = 8'h03;
            default: b = 8'($urandom_range(0, 255));
          endcase
        end else if (k == 1) begin
          b = 8'($urandom_range(0, 11));
        end else begin
          b = 8'($urandom_range(0, 255));
        end
        send_byte(b);
      end
      end_frame();
    end

    // async reset between edges after one committed write, frame still active
    start_frame(); send_byte(8'h01); send_byte(8'h04); send_byte(8'hAB);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_tx", {56'd0, bus.tx_byte}, 64'd0);
    check("arst_reg_flat", reg_flat, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_err", {56'd0, err_count}, 64'd0);
    check("arst_wr_strobe", {63'd0, wr_strobe}, 64'd0);
    check("arst_wr_data", {56'd0, wr_data}, 64'd0);
    @(negedge ico_clk);
    rst = 1'b0;
    idle(2);
    check("arst_resume_busy", {63'd0, busy}, 64'd1);
    send_byte(8'h01);
    end_frame();

    // saturation of the 2-bit counter
    for (int f = 0; f < 5; f++) begin
      start_frame(); send_byte(8'hEE); end_frame();
    end
    check("sat_final", {62'd0, err_count2}, 64'd3);
    check("err_final", {56'd0, err_count}, 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Downstream consumer of the icoboard SPI byte receiver. Takes received bytes and the synchronised chip-select state, and parses each SPI frame as a command packet: command, address, then a data stream. Writes an on-FPGA register bank that drives board I/O. Supplies the byte the receiver shifts back to the Raspberry Pi on the next exchange, which allows register reads over the same link.

Parameters:
NREGS, 8, number of 8-bit registers in the bank; legal range 2..16
ERR_W, 8, width of the saturating protocol error counter

Ports:
ico_clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous reset, active-high
frame_active  input  1  synchronised chip-select active (1 = frame in progress)
rx_valid  input  1  one-cycle strobe: rx_byte holds a complete received byte
rx_byte  input  8  received byte, MSB first on the wire
tx_byte  output  8  byte the receiver loads for the next exchange
wr_strobe  output  1  one-cycle pulse per committed register write
wr_addr  output  4  address of the committed write
wr_data  output  8  data of the committed write
reg_flat  output  8*NREGS  register bank; reg i at bits [8i+7:8i]
err_count  output  ERR_W  count of protocol errors, saturating
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all registers 0x00; tx_byte 0x00; wr_strobe 0; wr_addr 0; wr_data 0x00; err_count 0; address pointer 0.
- A byte is accepted only when rx_valid=1 and frame_active=1 in the same cycle. An rx_valid with frame_active=0 is ignored, with no state change.
- frame_active=0 in any cycle forces the state to IDLE on the next edge and tx_byte to 0x00. Registers and err_count are preserved. Writes already committed stay committed. A partial packet is dropped silently and does not count as an error.
- States:
  - IDLE: frame_active=1 -> CMD.
  - CMD: accepted byte 0x01 -> WADDR; 0x02 -> RADDR; 0x03 -> STAT; any other value -> DISCARD with err_count+1.
  - WADDR / RADDR: accepted byte b. If b < NREGS: pointer <= b[3:0], then -> WDATA / RDATA. Otherwise -> DISCARD with err_count+1.
  - WDATA: each accepted byte writes reg[pointer]. wr_strobe pulses one cycle after acceptance, with wr_addr=pointer and wr_data=byte. The pointer then increments and wraps NREGS-1 -> 0.
  - RDATA: each accepted byte is a dummy, and its value is ignored. The pointer increments with wrap.
  - STAT: stays in STAT; bytes are ignored.
  - DISCARD: all bytes are ignored until the frame ends.
- tx_byte updates on the edge following acceptance, i.e. latency 1 cycle:
  - in CMD, after a valid command byte: echo of the command;
  - after an in-range RADDR byte: reg[b];
  - after each RDATA byte: reg[pointer+1 mod NREGS];
  - after entering STAT: err_count[7:0] (zero-extended if ERR_W<8);
  - in WADDR, WDATA and DISCARD: 0x00.
- A register written in WDATA is visible in reg_flat on the same edge that wr_strobe rises.
- err_count saturates at 2^ERR_W-1 and never wraps.
- rx_valid never occurs on consecutive cycles. The receiver needs at least 8 SPI clocks per byte, so no pipelining or backpressure is needed.
- Frame end in the same cycle as rx_valid: the byte is ignored, because frame_active qualifies acceptance.
- Reset asserted mid-frame: immediate return to reset values. After reset release, the decoder enters CMD only once frame_active is seen high. If the frame is still active, the next accepted byte is treated as a command.

Test Plan:
- Reset then write: frame with bytes 0x01,0x03,0x5A,0xC3 -> reg3=0x5A, reg4=0xC3; two wr_strobe pulses with addr 3 then 4; err_count=0; tx_byte 0x01 after the command, 0x00 afterwards.
- Read with wrap (NREGS=8): preload reg7=0x11, reg0=0x22; frame 0x02,0x07,0xFF,0xFF -> tx_byte 0x02, then 0x11, then 0x22, then reg1; no wr_strobe.
- Errors: frame 0x7E,0x01 -> DISCARD, err_count=1, no write. Frame 0x01,0x09 -> err_count=2. Frame 0x03 -> tx_byte 0x02.
- Frame abort: frame 0x01,0x02 then frame_active drops before the data byte -> state IDLE, reg2 unchanged, err_count unchanged. The next frame 0x01,0x02,0x44 writes reg2=0x44.
- Qualification: rx_valid pulses with frame_active=0 carrying 0x01 -> no state change. rx_valid coinciding with frame_active falling -> byte ignored.
- Async reset mid-WDATA after one write: rst pulsed between edges -> outputs 0 immediately, reg_flat all zero, busy=0. Saturation check with ERR_W=2: five bad frames -> err_count=3.
